// File: rtl/axi4_lite_bus_wr_fifo.sv
// AXI4-Lite write-path decoupler: independent FWFT FIFOs on AW and W toward the target and on B back to the initiator.
// Optional macro AXI4_WR_FIFO_CREDIT_EN: outstanding-write credit limits AW so the B FIFO can never refuse a response.
module axi4_lite_bus_wr_fifo #(
  parameter int unsigned A = 32,
  parameter int unsigned N = 4,
  parameter int unsigned D = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [A-1:0]   s_awaddr,
  input  logic           s_awvalid,
  output logic           s_awready,
  input  logic [8*N-1:0] s_wdata,
  input  logic [N-1:0]   s_wstrb,
  input  logic           s_wvalid,
  output logic           s_wready,
  output logic [1:0]     s_bresp,
  output logic           s_bvalid,
  input  logic           s_bready,
  output logic [A-1:0]   m_awaddr,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [8*N-1:0] m_wdata,
  output logic [N-1:0]   m_wstrb,
  output logic           m_wvalid,
  input  logic           m_wready,
  input  logic [1:0]     m_bresp,
  input  logic           m_bvalid,
  output logic           m_bready
);

  localparam int unsigned PW = $clog2(D);
  localparam int unsigned WW = 8*N + N;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(D);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  // Readies stay low during reset and rise on the first edge after release.
  logic run;
  logic credit_ok;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  // ---------------- AW FIFO ----------------
  logic [A-1:0] aw_mem [D];
  ptr_t         aw_wr_ptr, aw_rd_ptr;
  cnt_t         aw_cnt;
  logic         aw_full, aw_push, aw_pop;

  assign aw_full   = (aw_cnt == FULL_CNT);
  assign s_awready = run & ~aw_full & credit_ok;
  assign m_awvalid = (aw_cnt != '0);
  assign m_awaddr  = aw_mem[aw_rd_ptr];
  assign aw_push   = s_awvalid & s_awready;
  assign aw_pop    = m_awvalid & m_awready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_cnt    <= '0;
    end else begin
      if (aw_push) aw_wr_ptr <= aw_wr_ptr + 1'b1;
      if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + 1'b1;
      if (aw_push != aw_pop) aw_cnt <= aw_push ? aw_cnt + 1'b1 : aw_cnt - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_push) aw_mem[aw_wr_ptr] <= s_awaddr;
  end

  // ---------------- W FIFO (strobe and data stored together) ----------------
  logic [WW-1:0] w_mem [D];
  logic [WW-1:0] w_head;
  ptr_t          w_wr_ptr, w_rd_ptr;
  cnt_t          w_cnt;
  logic          w_full, w_push, w_pop;

  assign w_full   = (w_cnt == FULL_CNT);
  assign s_wready = run & ~w_full;
  assign m_wvalid = (w_cnt != '0);
  assign w_head   = w_mem[w_rd_ptr];
  assign m_wdata  = w_head[8*N-1:0];
  assign m_wstrb  = w_head[8*N +: N];
  assign w_push   = s_wvalid & s_wready;
  assign w_pop    = m_wvalid & m_wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_cnt    <= '0;
    end else begin
      if (w_push) w_wr_ptr <= w_wr_ptr + 1'b1;
      if (w_pop)  w_rd_ptr <= w_rd_ptr + 1'b1;
      if (w_push != w_pop) w_cnt <= w_push ? w_cnt + 1'b1 : w_cnt - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) w_mem[w_wr_ptr] <= {s_wstrb, s_wdata};
  end

  // ---------------- B FIFO ----------------
  logic [1:0] b_mem [D];
  ptr_t       b_wr_ptr, b_rd_ptr;
  cnt_t       b_cnt;
  logic       b_full, b_push, b_pop;

  assign b_full   = (b_cnt == FULL_CNT);
  assign s_bvalid = (b_cnt != '0);
  assign s_bresp  = b_mem[b_rd_ptr];
  // The full guard is redundant under credit control but keeps storage safe from a misbehaving target.
  assign b_push   = m_bvalid & m_bready & ~b_full;
  assign b_pop    = s_bvalid & s_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_cnt    <= '0;
    end else begin
      if (b_push) b_wr_ptr <= b_wr_ptr + 1'b1;
      if (b_pop)  b_rd_ptr <= b_rd_ptr + 1'b1;
      if (b_push != b_pop) b_cnt <= b_push ? b_cnt + 1'b1 : b_cnt - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (b_push) b_mem[b_wr_ptr] <= m_bresp;
  end

  // ---------------- Credit control ----------------
`ifdef AXI4_WR_FIFO_CREDIT_EN
  cnt_t outstanding;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else if (aw_push != b_pop) begin
      outstanding <= aw_push ? outstanding + 1'b1 : outstanding - 1'b1;
    end
  end

  assign credit_ok = (outstanding != FULL_CNT);
  assign m_bready  = run;
`else
  assign credit_ok = 1'b1;
  assign m_bready  = run & ~b_full;
`endif

endmodule
